// File: rtl/instr_classifier_pkg.sv
// Shared definitions for the instruction classifier: widths, instruction IDs,
// format codes and functional-class codes.
package instr_classifier_pkg;

  localparam int WIDTH_INSTR  = 6;
  localparam int WIDTH_FORMAT = 2;
  localparam int WIDTH_FUNC   = 4;

  // Encoding format of an instruction
  typedef enum logic [WIDTH_FORMAT-1:0] {
    F_NONE = 2'd0,
    F_R    = 2'd1,
    F_I    = 2'd2,
    F_J    = 2'd3
  } format_e;

  // Functional class used by next-PC, hazard and forwarding logic
  typedef enum logic [WIDTH_FUNC-1:0] {
    I_NOP    = 4'd0,
    I_ALU_R  = 4'd1,
    I_ALU_I  = 4'd2,
    I_MEM_R  = 4'd3,
    I_MEM_W  = 4'd4,
    I_BRANCH = 4'd5,
    I_JUMP   = 4'd6,
    I_MD     = 4'd7,
    I_CP0    = 4'd8
  } ifunc_e;

  // Pre-decoded instruction IDs. ID 0 is NOP/unknown; 54..63 are unused.
  typedef enum logic [WIDTH_INSTR-1:0] {
    ID_NOP   = 6'd0,
    ID_ADD   = 6'd1,  ID_ADDU  = 6'd2,  ID_SUB   = 6'd3,  ID_SUBU  = 6'd4,
    ID_AND   = 6'd5,  ID_OR    = 6'd6,  ID_XOR   = 6'd7,  ID_NOR   = 6'd8,
    ID_SLT   = 6'd9,  ID_SLTU  = 6'd10, ID_SLL   = 6'd11, ID_SRL   = 6'd12,
    ID_SRA   = 6'd13, ID_SLLV  = 6'd14, ID_SRLV  = 6'd15, ID_SRAV  = 6'd16,
    ID_ADDI  = 6'd17, ID_ADDIU = 6'd18, ID_ANDI  = 6'd19, ID_ORI   = 6'd20,
    ID_XORI  = 6'd21, ID_SLTI  = 6'd22, ID_SLTIU = 6'd23, ID_LUI   = 6'd24,
    ID_LW    = 6'd25, ID_LH    = 6'd26, ID_LHU   = 6'd27, ID_LB    = 6'd28,
    ID_LBU   = 6'd29,
    ID_SW    = 6'd30, ID_SH    = 6'd31, ID_SB    = 6'd32,
    ID_BEQ   = 6'd33, ID_BNE   = 6'd34, ID_BLEZ  = 6'd35, ID_BGTZ  = 6'd36,
    ID_BLTZ  = 6'd37, ID_BGEZ  = 6'd38,
    ID_J     = 6'd39, ID_JAL   = 6'd40, ID_JR    = 6'd41, ID_JALR  = 6'd42,
    ID_MULT  = 6'd43, ID_MULTU = 6'd44, ID_DIV   = 6'd45, ID_DIVU  = 6'd46,
    ID_MFHI  = 6'd47, ID_MFLO  = 6'd48, ID_MTHI  = 6'd49, ID_MTLO  = 6'd50,
    ID_MFC0  = 6'd51, ID_MTC0  = 6'd52, ID_ERET  = 6'd53
  } instr_id_e;

  localparam int NUM_IDS = 54;

  // Classification result carried through the LUT and output register
  typedef struct packed {
    format_e fmt;
    ifunc_e  func;
  } class_t;

  localparam class_t CLASS_NONE = '{fmt: F_NONE, func: I_NOP};

endpackage

// File: rtl/instr_classifier_lut.sv
// Pure combinational ROM: instruction ID -> {format, functional class}.
// Anything not listed (NOP, unused IDs) maps to F_NONE/I_NOP, never X.
module instr_classifier_lut
  import instr_classifier_pkg::*;
(
  input  logic [WIDTH_INSTR-1:0] instr,
  output class_t                 cls
);

  // Case-statement lookup with an all-zero default
  always_comb begin
    cls = CLASS_NONE;
    case (instr)
      ID_ADD, ID_ADDU, ID_SUB, ID_SUBU, ID_AND, ID_OR, ID_XOR, ID_NOR,
      ID_SLT, ID_SLTU, ID_SLL, ID_SRL, ID_SRA, ID_SLLV, ID_SRLV, ID_SRAV:
        cls = '{fmt: F_R, func: I_ALU_R};
      ID_ADDI, ID_ADDIU, ID_ANDI, ID_ORI, ID_XORI, ID_SLTI, ID_SLTIU, ID_LUI:
        cls = '{fmt: F_I, func: I_ALU_I};
      ID_LW, ID_LH, ID_LHU, ID_LB, ID_LBU:
        cls = '{fmt: F_I, func: I_MEM_R};
      ID_SW, ID_SH, ID_SB:
        cls = '{fmt: F_I, func: I_MEM_W};
      ID_BEQ, ID_BNE, ID_BLEZ, ID_BGTZ, ID_BLTZ, ID_BGEZ:
        cls = '{fmt: F_I, func: I_BRANCH};
      ID_J, ID_JAL:
        cls = '{fmt: F_J, func: I_JUMP};
      // register-target jumps use the R encoding
      ID_JR, ID_JALR:
        cls = '{fmt: F_R, func: I_JUMP};
      ID_MULT, ID_MULTU, ID_DIV, ID_DIVU, ID_MFHI, ID_MFLO, ID_MTHI, ID_MTLO:
        cls = '{fmt: F_R, func: I_MD};
      ID_MFC0, ID_MTC0, ID_ERET:
        cls = '{fmt: F_R, func: I_CP0};
      default:
        cls = CLASS_NONE;
    endcase
  end

endmodule

// File: rtl/instr_classifier.sv
// Instruction classifier: zero-latency format/func lookup plus a one-cycle
// registered copy for pipelined consumers. Reset only clears the registered copy.
module instr_classifier
  import instr_classifier_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH_INSTR-1:0]  instr,
  output logic [WIDTH_FORMAT-1:0] format,
  output logic [WIDTH_FUNC-1:0]   func,
  output logic [WIDTH_FORMAT-1:0] format_q,
  output logic [WIDTH_FUNC-1:0]   func_q
);

  class_t cls;
  class_t cls_q;

  instr_classifier_lut u_lut (
    .instr (instr),
    .cls   (cls)
  );

  // Register the live classification every edge; reset wins over instr
  always_ff @(posedge clk) begin
    if (reset) cls_q <= CLASS_NONE;
    else       cls_q <= cls;
  end

  assign format   = cls.fmt;
  assign func     = cls.func;
  assign format_q = cls_q.fmt;
  assign func_q   = cls_q.func;

endmodule

// File: tb/tb_instr_classifier.sv
// Scoreboard bench for instr_classifier: the driver checks the combinational
// outputs and queues the expected registered value; a monitor pops and checks
// format_q/func_q after every rising edge.
module tb_instr_classifier;
  import instr_classifier_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] instr = '0;
  logic [1:0] format, format_q;
  logic [3:0] func, func_q;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int fmt;
    int fn;
    string tag;
  } exp_t;

  exp_t sb_q[$];

  // reference tables: expected format/class per ID, default NOP/NONE
  int ref_fmt[64];
  int ref_fn[64];

  instr_classifier dut (
    .clk      (clk),
    .reset    (reset),
    .instr    (instr),
    .format   (format),
    .func     (func),
    .format_q (format_q),
    .func_q   (func_q)
  );

  always #5 clk = ~clk;

  task automatic add_group(input int ids[$], input int f, input int c);
    foreach (ids[i]) begin
      ref_fmt[ids[i]] = f;
      ref_fn[ids[i]]  = c;
    end
  endtask

  task automatic build_ref();
    for (int i = 0; i < 64; i++) begin
      ref_fmt[i] = 0;
      ref_fn[i]  = 0;
    end
    add_group('{ID_ADD, ID_ADDU, ID_SUB, ID_SUBU, ID_AND, ID_OR, ID_XOR, ID_NOR,
                ID_SLT, ID_SLTU, ID_SLL, ID_SRL, ID_SRA, ID_SLLV, ID_SRLV, ID_SRAV}, 1, 1);
    add_group('{ID_ADDI, ID_ADDIU, ID_ANDI, ID_ORI, ID_XORI, ID_SLTI, ID_SLTIU, ID_LUI}, 2, 2);
    add_group('{ID_LW, ID_LH, ID_LHU, ID_LB, ID_LBU}, 2, 3);
    add_group('{ID_SW, ID_SH, ID_SB}, 2, 4);
    add_group('{ID_BEQ, ID_BNE, ID_BLEZ, ID_BGTZ, ID_BLTZ, ID_BGEZ}, 2, 5);
    add_group('{ID_J, ID_JAL}, 3, 6);
    add_group('{ID_JR, ID_JALR}, 1, 6);
    add_group('{ID_MULT, ID_MULTU, ID_DIV, ID_DIVU, ID_MFHI, ID_MFLO, ID_MTHI, ID_MTLO}, 1, 7);
    add_group('{ID_MFC0, ID_MTC0, ID_ERET}, 1, 8);
  endtask

  task automatic check(input string tag, input int act_f, input int act_c,
                       input int exp_f, input int exp_c, input logic has_x);
    tests++;
    if (has_x || act_f != exp_f || act_c != exp_c) begin
      fails++;
      $display("FAIL %s: got fmt=%0d func=%0d x=%0b, want fmt=%0d func=%0d",
               tag, act_f, act_c, has_x, exp_f, exp_c);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, check comb outputs,
  // queue the value the register must hold after the next rising edge.
  task automatic drive(input int id, input logic rst, input string tag);
    exp_t e;
    @(negedge clk);
    instr = id[5:0];
    reset = rst;
    #1;
    check({tag, "/comb"}, int'(format), int'(func), ref_fmt[id], ref_fn[id],
          $isunknown({format, func}));
    e.fmt = rst ? 0 : ref_fmt[id];
    e.fn  = rst ? 0 : ref_fn[id];
    e.tag = {tag, "/reg"};
    sb_q.push_back(e);
  endtask

  // Monitor: compare registered outputs just after each rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, int'(format_q), int'(func_q), e.fmt, e.fn, $isunknown({format_q, func_q}));
    end
  end

  initial begin
    int id;
    build_ref();

    // reset state
    drive(ID_BEQ, 1'b1, "reset_init");
    drive(ID_NOP, 1'b1, "reset_hold");

    // directed classification cases
    drive(ID_BEQ,  1'b0, "beq");
    drive(ID_JR,   1'b0, "jr");
    drive(ID_JAL,  1'b0, "jal");
    drive(ID_J,    1'b0, "j");
    drive(ID_LW,   1'b0, "lw");
    drive(ID_SB,   1'b0, "sb");
    drive(ID_ADDU, 1'b0, "addu");
    drive(ID_ERET, 1'b0, "eret");
    drive(ID_MFLO, 1'b0, "mflo");
    drive(ID_LUI,  1'b0, "lui");
    drive(0,       1'b0, "nop");
    drive(63,      1'b0, "unused3f");
    drive(54,      1'b0, "unused36");

    // reset mid-stream with BEQ held: register clears, comb stays, then resumes
    drive(ID_BEQ, 1'b0, "beq_pre");
    drive(ID_BEQ, 1'b1, "beq_rst");
    drive(ID_BEQ, 1'b0, "beq_resume");

    // full sweep of every ID value
    for (int i = 0; i < 64; i++) drive(i, 1'b0, $sformatf("sweep%0d", i));

    // randomized IDs with occasional reset
    for (int i = 0; i < 200; i++) begin
      id = int'($urandom_range(0, 63));
      drive(id, ($urandom_range(0, 15) == 0), $sformatf("rand%0d_id%0d", i, id));
    end

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    if (sb_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, want finish before it");
    $fatal(1, "timeout");
  end

endmodule
